// File: rtl/inst_fetch_apb_pkg.sv
// Shared types and constants for the NanoQuarter instruction fetch unit.
package nq_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        HOLD
    } fetch_state_e;

    localparam int NQ_INST_W  = 16;
    localparam int NQ_WORD_W  = 32;
    localparam int NQ_PC_STEP = 4;

endpackage

// File: rtl/inst_fetch_apb_if.sv
// APB read-side bus between the fetch unit (master) and instruction memory (slave).
interface inst_fetch_apb_if;
    import nq_fetch_pkg::*;

    logic [NQ_WORD_W-1:0] paddr;
    logic                 psel;
    logic                 penable;
    logic                 pwrite;
    logic [NQ_WORD_W-1:0] prdata;
    logic                 pready;
    logic                 pslverr;

    modport master (
        output paddr, psel, penable, pwrite,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  paddr, psel, penable, pwrite,
        output prdata, pready, pslverr
    );

endinterface

// File: rtl/inst_fetch_apb.sv
// APB fetch master: one 32-bit word per transfer, delivered to the prefetch buffer
// as two 16-bit instructions with a one-cycle write strobe. Handles redirect and stall.
module inst_fetch_apb
    import nq_fetch_pkg::*;
#(
    parameter logic [NQ_WORD_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    inst_fetch_apb_if.master     apb,
    input  logic                 stall_flg,
    input  logic                 branch_en,
    input  logic [NQ_WORD_W-1:0] branch_pc,
    output logic [NQ_INST_W-1:0] inst1,
    output logic [NQ_INST_W-1:0] inst2,
    output logic [NQ_WORD_W-1:0] PC_out,
    output logic                 write,
    output logic                 fetch_err
);

    fetch_state_e         state, state_n;
    logic [NQ_WORD_W-1:0] pc, pc_n;
    logic [NQ_WORD_W-1:0] br_tgt, tgt_n;
    logic                 br_pend, pend_n;
    logic                 load, write_n, err_n;

    // pc only moves when a transfer finishes or a redirect lands, so it doubles as paddr
    assign apb.paddr   = pc;
    assign apb.psel    = (state == SETUP) || (state == ACCESS);
    assign apb.penable = (state == ACCESS);
    assign apb.pwrite  = 1'b0;

    always_comb begin
        state_n = state;
        pc_n    = pc;
        load    = 1'b0;
        write_n = 1'b0;
        err_n   = 1'b0;
        tgt_n   = branch_en ? {branch_pc[NQ_WORD_W-1:2], 2'b00} : br_tgt;
        pend_n  = br_pend | branch_en;
        case (state)
            IDLE: begin
                // no transfer in flight: a redirect lands immediately
                if (branch_en)       pc_n    = tgt_n;
                else if (!stall_flg) state_n = SETUP;
            end
            SETUP: state_n = ACCESS;
            ACCESS: begin
                if (apb.pready) begin
                    if (apb.pslverr) begin
                        err_n   = 1'b1;
                        state_n = IDLE;
                    end else if (br_pend || branch_en) begin
                        pc_n    = tgt_n;
                        state_n = IDLE;
                    end else begin
                        load = 1'b1;
                        pc_n = pc + NQ_WORD_W'(NQ_PC_STEP);
                        if (!stall_flg) begin
                            write_n = 1'b1;
                            state_n = SETUP;
                        end else begin
                            state_n = HOLD;
                        end
                    end
                end
            end
            HOLD: begin
                if (branch_en) begin
                    pc_n    = tgt_n;
                    state_n = IDLE;
                end else if (!stall_flg) begin
                    write_n = 1'b1;
                    state_n = SETUP;
                end
            end
            default: state_n = IDLE;
        endcase
        if (state_n == IDLE) pend_n = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            br_tgt    <= '0;
            br_pend   <= 1'b0;
            inst1     <= '0;
            inst2     <= '0;
            PC_out    <= '0;
            write     <= 1'b0;
            fetch_err <= 1'b0;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            br_tgt    <= tgt_n;
            br_pend   <= pend_n;
            write     <= write_n;
            fetch_err <= err_n;
            if (load) begin
                inst1  <= apb.prdata[NQ_INST_W-1:0];
                inst2  <= apb.prdata[NQ_WORD_W-1:NQ_INST_W];
                PC_out <= pc;
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch_apb.sv
// Directed bench for inst_fetch_apb: APB memory model plus cycle-stamped scoreboards
// for write strobes, SETUP addresses and fetch_err pulses.
module tb_inst_fetch_apb;
    import nq_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_flg = 1'b0;
    logic        branch_en = 1'b0;
    logic [31:0] branch_pc = 32'h0;
    logic [15:0] inst1, inst2;
    logic [31:0] PC_out;
    logic        write, fetch_err;

    inst_fetch_apb_if apb();

    inst_fetch_apb #(.RESET_PC(32'h0000_0000)) dut (
        .clk       (clk),
        .rst       (rst),
        .apb       (apb),
        .stall_flg (stall_flg),
        .branch_en (branch_en),
        .branch_pc (branch_pc),
        .inst1     (inst1),
        .inst2     (inst2),
        .PC_out    (PC_out),
        .write     (write),
        .fetch_err (fetch_err)
    );

    always #5 clk = ~clk;

    // memory model; wait states and errors are keyed on the transfer index since reset
    int xfer_cnt = 0;
    int wcnt     = 0;
    int wait_idx = -1;
    int wait_n   = 0;
    int err_idx  = -1;

    function automatic logic [31:0] mem(input logic [31:0] a);
        case (a)
            32'h000: mem = 32'hBBBB_AAAA;
            32'h004: mem = 32'hDDDD_CCCC;
            32'h008: mem = 32'h2222_1111;
            32'h00C: mem = 32'h4444_3333;
            32'h100: mem = 32'h6666_5555;
            32'h104: mem = 32'h8888_7777;
            default: mem = {a[15:0] ^ 16'h5A5A, a[15:0]};
        endcase
    endfunction

    assign apb.prdata  = mem(apb.paddr);
    assign apb.pready  = (wcnt == 0);
    assign apb.pslverr = apb.pready && (xfer_cnt == err_idx);

    always @(posedge clk) begin
        if (rst) begin
            xfer_cnt <= 0;
            wcnt     <= 0;
        end else if (apb.psel && !apb.penable) begin
            wcnt <= (xfer_cnt == wait_idx) ? wait_n : 0;
        end else if (apb.psel && apb.penable) begin
            if (wcnt != 0) wcnt <= wcnt - 1;
            else           xfer_cnt <= xfer_cnt + 1;
        end
    end

    // scoreboard
    typedef struct { int cyc; logic [15:0] i1; logic [15:0] i2; logic [31:0] pc; } wr_t;
    typedef struct { int cyc; logic [31:0] a; } ad_t;
    wr_t wq[$];
    ad_t aq[$];
    int  eq[$];
    int  vectors = 0;
    int  errors  = 0;
    int  cyc     = 0;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic void unexpected(input string nm);
        vectors++;
        errors++;
        $display("FAIL %s: event with nothing expected (cycle %0d)", nm, cyc);
    endfunction

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    wr_t         w;
    ad_t         ad;
    logic [31:0] cur_addr = 32'h0;
    logic        prev_wr = 1'b0;

    always @(negedge clk) begin
        if (cyc > 0) begin
            if (write) begin
                chk("write_gap", 64'(prev_wr), 64'd0);
                if (wq.size() == 0) unexpected("write");
                else begin
                    w = wq.pop_front();
                    chk("write_cycle", 64'(cyc), 64'(w.cyc));
                    chk("write_pair", {inst1, inst2, PC_out}, {w.i1, w.i2, w.pc});
                end
            end
            if (apb.psel && !apb.penable) begin
                if (aq.size() == 0) unexpected("setup");
                else begin
                    ad = aq.pop_front();
                    chk("setup_cycle", 64'(cyc), 64'(ad.cyc));
                    chk("setup_addr", 64'(apb.paddr), 64'(ad.a));
                    cur_addr = ad.a;
                end
            end
            if (apb.psel && apb.penable) chk("access_addr", 64'(apb.paddr), 64'(cur_addr));
            if (fetch_err) begin
                if (eq.size() == 0) unexpected("fetch_err");
                else chk("fetch_err_cycle", 64'(cyc), 64'(eq.pop_front()));
            end
        end
        prev_wr = write;
    end

    task automatic exp_wr(input int c, input logic [15:0] i1, input logic [15:0] i2,
                          input logic [31:0] pc);
        wr_t e;
        e.cyc = c; e.i1 = i1; e.i2 = i2; e.pc = pc;
        wq.push_back(e);
    endtask

    task automatic exp_ad(input int c, input logic [31:0] a);
        ad_t e;
        e.cyc = c; e.a = a;
        aq.push_back(e);
    endtask

    // called on a negedge; checks reset values and that the previous test drained its queues
    task automatic do_reset();
        rst       = 1'b1;
        stall_flg = 1'b0;
        branch_en = 1'b0;
        @(negedge clk);
        chk("rst_bus", {apb.psel, apb.penable, apb.pwrite, apb.paddr}, 64'd0);
        chk("rst_out", {write, fetch_err, inst1, inst2, PC_out}, 64'd0);
        chk("left_write", 64'(wq.size()), 64'd0);
        chk("left_setup", 64'(aq.size()), 64'd0);
        chk("left_err", 64'(eq.size()), 64'd0);
        wq.delete(); aq.delete(); eq.delete();
        wait_idx = -1; wait_n = 0; err_idx = -1;
        @(negedge clk);
    endtask

    task automatic at_step(input int k);
        int guard = 0;
        while (cyc < k && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (cyc != k) unexpected("step_timeout");
    endtask

    initial begin
        @(negedge clk);
        do_reset();

        // zero-wait fetch from reset, then reset while @8 is in ACCESS
        exp_ad(1, 32'h0); exp_ad(3, 32'h4); exp_ad(5, 32'h8);
        exp_wr(3, 16'hAAAA, 16'hBBBB, 32'h0);
        exp_wr(5, 16'hCCCC, 16'hDDDD, 32'h4);
        rst = 1'b0;
        at_step(6);
        do_reset();

        // three wait states on the @0 access
        wait_idx = 0; wait_n = 3;
        exp_ad(1, 32'h0); exp_ad(6, 32'h4); exp_ad(8, 32'h8);
        exp_wr(6, 16'hAAAA, 16'hBBBB, 32'h0);
        exp_wr(8, 16'hCCCC, 16'hDDDD, 32'h4);
        rst = 1'b0;
        at_step(8);
        do_reset();

        // stall across the @8 completion for four cycles
        exp_ad(1, 32'h0); exp_ad(3, 32'h4); exp_ad(5, 32'h8); exp_ad(11, 32'hC); exp_ad(13, 32'h10);
        exp_wr(3, 16'hAAAA, 16'hBBBB, 32'h0);
        exp_wr(5, 16'hCCCC, 16'hDDDD, 32'h4);
        exp_wr(11, 16'h1111, 16'h2222, 32'h8);
        exp_wr(13, 16'h3333, 16'h4444, 32'hC);
        rst = 1'b0;
        at_step(6);  stall_flg = 1'b1;
        at_step(10); stall_flg = 1'b0;
        at_step(13);
        do_reset();

        // branch to 0x103 during ACCESS @4
        exp_ad(1, 32'h0); exp_ad(3, 32'h4); exp_ad(6, 32'h100); exp_ad(8, 32'h104);
        exp_wr(3, 16'hAAAA, 16'hBBBB, 32'h0);
        exp_wr(8, 16'h5555, 16'h6666, 32'h100);
        rst = 1'b0;
        at_step(4); branch_en = 1'b1; branch_pc = 32'h103;
        at_step(5); branch_en = 1'b0;
        at_step(8);
        do_reset();

        // slave error on @8, retried
        err_idx = 2;
        exp_ad(1, 32'h0); exp_ad(3, 32'h4); exp_ad(5, 32'h8); exp_ad(8, 32'h8); exp_ad(10, 32'hC);
        exp_wr(3, 16'hAAAA, 16'hBBBB, 32'h0);
        exp_wr(5, 16'hCCCC, 16'hDDDD, 32'h4);
        exp_wr(10, 16'h1111, 16'h2222, 32'h8);
        eq.push_back(7);
        rst = 1'b0;
        at_step(10);
        do_reset();

        // branch while holding a stalled pair: pair dropped, fetch resumes at target
        exp_ad(1, 32'h0); exp_ad(3, 32'h4); exp_ad(5, 32'h8); exp_ad(10, 32'h104); exp_ad(12, 32'h108);
        exp_wr(3, 16'hAAAA, 16'hBBBB, 32'h0);
        exp_wr(5, 16'hCCCC, 16'hDDDD, 32'h4);
        exp_wr(12, 16'h7777, 16'h8888, 32'h104);
        rst = 1'b0;
        at_step(6); stall_flg = 1'b1;
        at_step(8); branch_en = 1'b1; branch_pc = 32'h106;
        at_step(9); branch_en = 1'b0; stall_flg = 1'b0;
        at_step(12);
        do_reset();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/inst_fetch_apb.md
# inst_fetch_apb

Instruction fetch unit for the NanoQuarter core: an APB read master that fetches one 32-bit word per transfer from instruction memory and hands it to the prefetch buffer as two 16-bit instructions plus the word's PC. Its one-cycle `write` strobe loads the prefetch buffer. That buffer issues `inst1` on the strobe cycle and `inst2` on the following cycle, which hides the one-cycle APB latency. The block owns the fetch PC and handles redirect (`branch_en`) and `stall_flg` back-pressure.

## Interface
- `RESET_PC`, default 32'h0000_0000: byte address of the first fetch after reset.
- `clk` in 1: system clock; every register is clocked on the rising edge.
- `rst` in 1: system reset, synchronous, active-high.
- `stall_flg` in 1: core stall; while high, no new pair is delivered and no new transfer starts.
- `branch_en` in 1: one-cycle redirect request.
- `branch_pc` in 32: redirect target; bits [1:0] are ignored (word-aligned).
- `paddr` out 32: APB address.
- `psel` out 1: APB select.
- `penable` out 1: APB enable.
- `pwrite` out 1: tied 0.
- `prdata` in 32: APB read data.
- `pready` in 1: APB ready.
- `pslverr` in 1: APB error.
- `inst1` out 16: first instruction, `prdata[15:0]` (lower halfword address).
- `inst2` out 16: second instruction, `prdata[31:16]`.
- `PC_out` out 32: byte address of `inst1`.
- `write` out 1: pair-valid strobe to the prefetch buffer.
- `fetch_err` out 1: one-cycle pulse on `pslverr`.

## Operation
- Reset values: state IDLE, `pc` = `RESET_PC`, `paddr` = `RESET_PC`, `psel`/`penable`/`write`/`fetch_err` = 0, `inst1`/`inst2`/`PC_out` = 0, branch-pending flag = 0.
- **IDLE**
  - `!stall_flg`: go to SETUP with `paddr` = `pc`.
  - Otherwise stay in IDLE.
- **SETUP**
  - Outputs: `psel`=1, `penable`=0.
  - Always go to ACCESS next cycle.
- **ACCESS**
  - Outputs: `psel`=1, `penable`=1.
  - Hold while `!pready`; `paddr` stays stable.
  - On `pready`, the following cases apply in priority order:
    1. `pslverr`: pulse `fetch_err`, discard the data, keep `pc`, go to IDLE (the same word is retried).
    2. Branch pending, or `branch_en` in this cycle: discard the data, `pc` = target, go to IDLE.
    3. Otherwise: load `inst1`, `inst2` and `PC_out` = `pc`, then `pc` += 4 (modulo 2^32).
       - If `!stall_flg`: `write`=1 next cycle and go straight to SETUP.
       - If `stall_flg`: go to HOLD.
- **HOLD**
  - The pair stays on the outputs.
  - When `stall_flg` drops: `write`=1 for one cycle, then go to SETUP.
  - `branch_en` in HOLD: discard the pair (no `write`), `pc` = target, go to IDLE.
- **Branch**
  - `branch_en` in any state latches `branch_pc & ~3` and sets the pending flag.
  - A started APB transfer is never aborted; it completes and its data is dropped.
  - A pending branch takes priority over a stall.
  - The pending flag clears when IDLE is entered.
  - A later `branch_en` overwrites the target.
- `write` is never high on two consecutive cycles. The prefetch buffer relies on this to present `inst2`.
- `inst1`/`inst2`/`PC_out` change only at the edge that also raises `write`, or on the HOLD entry edge; they are never changed while `write`=1.

## Timing
- **Zero-wait memory**
  - One transfer every 2 cycles (SETUP, ACCESS).
  - `write` is high every other cycle, which exactly matches the prefetch buffer's consumption of one instruction per cycle.
- **Latencies**
  - Fetch latency, reset release → first `write`: 3 cycles (IDLE, SETUP, ACCESS, then `write`).
  - `branch_en` → first `write` from the target: at most the remaining in-flight transfer + 3 cycles.
  - `stall_flg` low in HOLD → `write` on the next cycle.
- **Reset mid-transfer**: `psel`/`penable` drop at the reset edge; the in-flight data is ignored.
- **Simultaneous events**
  - `rst` beats everything.
  - Then `pslverr`.
  - Then branch.
  - Then stall.

## Structure
- Shared package `nq_fetch_pkg` holds:
  - the state enum (IDLE, SETUP, ACCESS, HOLD);
  - `NQ_INST_W`=16;
  - `NQ_WORD_W`=32;
  - `NQ_PC_STEP`=4.
- No sub-module; a single flat FSM with a datapath.

## Test plan
- Reset release, zero-wait memory returning 32'hBBBB_AAAA @0, 32'hDDDD_CCCC @4 → `paddr` 0 then 4; `write` on cycles 3 and 5; `inst1`/`inst2`/`PC_out` = AAAA/BBBB/0, then CCCC/DDDD/4.
- `pready` low for 3 cycles on the @0 access → `paddr` and `psel` stable; `write` is delayed by 3 cycles; values are correct.
- `stall_flg` high during ACCESS @8 for 4 cycles → no `write` and no new SETUP while high; `write` the cycle after release with `PC_out`=8; the next `paddr` is 12.
- `branch_en` with `branch_pc`=32'h103 during ACCESS @4 → the @4 data is dropped (no `write`); the next `paddr` is 32'h100; `PC_out`=32'h100 on the next `write`.
- `pslverr` on @8 → one-cycle `fetch_err` pulse, no `write`; @8 is re-fetched and then delivered normally.
- `rst` asserted in ACCESS → the next cycle has `psel`=0, `write`=0, `paddr`=`RESET_PC`; fetching restarts from `RESET_PC`.
